fifo_uart_tx_drain: RTL and testbench
=====================================

// Module: fifo_uart_tx_drain
// PURPOSE
//  Read side of the loopback path: drains bytes from sync_fifo (dev_clk domain) and hands them
//  one at a time to uart_tx, which runs on the divided clk_out. Owns fifo_rd_en and the uart_tx
//  en/data handshake; synchronises uart_tx ready into dev_clk and holds en until tx accepts.
// PARAMETERS
//  DATA_BITS       8     byte width; matches sync_fifo and uart_tx
//  SYNC_STAGES     2     flops in the uart_tx_ready synchroniser, min 2
//  TIMEOUT_CYCLES  4096  dev_clk cycles to wait for ready to drop after en raised
//  COUNT_BITS      16    width of tx_count
// PORTS
//  dev_clk        in   1           system clock, 25 MHz
//  n_rst_out      in   1           reset, asynchronous, active-low
//  fifo_empty     in   1           sync_fifo empty flag
//  fifo_rd_data   in   DATA_BITS   sync_fifo read data, valid 1 dev_clk after fifo_rd_en
//  fifo_rd_en     out  1           single-cycle read strobe
//  uart_tx_ready  in   1           uart_tx ready_out, clk_out domain; synchronised internally
//  uart_tx_en     out  1           request to uart_tx; held until accepted
//  uart_tx_data   out  DATA_BITS   byte to transmit; stable whenever uart_tx_en=1
//  busy           out  1           1 in any state other than IDLE
//  tx_count       out  COUNT_BITS  bytes handed to uart_tx, wraps at 2^COUNT_BITS
//  timeout_err    out  1           sticky; set on handshake timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchroniser flops 0 (ready treated low until synced).
//  rdy_s = last stage of SYNC_STAGES synchroniser on uart_tx_ready.
//  FSM, one transition max per dev_clk:
//   IDLE  : if !fifo_empty && rdy_s -> READ.
//   READ  : fifo_rd_en=1 for exactly this cycle -> LATCH.
//   LATCH : capture fifo_rd_data into hold reg -> SEND (or CR path, see CONFIGURATION).
//   SEND  : uart_tx_en=1, uart_tx_data=hold; timer counts; rdy_s==0 -> DONE, uart_tx_en=0
//           next cycle, tx_count+1; timer==TIMEOUT_CYCLES-1 -> timeout_err=1, en=0, -> DONE.
//   DONE  : wait rdy_s==1 (frame finished) -> IDLE (or SEND for pending LF).
//  uart_tx_data updated only in LATCH/CR load; never changes while uart_tx_en=1.
//  fifo_rd_en never asserted when fifo_empty=1 in the same cycle; at most one read per byte.
//  Latency fifo non-empty (rdy_s=1) to uart_tx_en rise: 3 dev_clk (IDLE, READ, LATCH).
//  fifo_empty rising during SEND/DONE: no effect until IDLE; byte already latched is sent.
//  tx_count wraps 2^COUNT_BITS-1 -> 0 silently. timeout_err cleared only by reset.
//  Reset mid-SEND: uart_tx_en drops asynchronously; held byte lost; FIFO not rewound.
// CONFIGURATION
//  Macro LF_TO_CRLF_EN:
//   defined   : LATCH with byte 8'h0A loads 8'h0D, sets lf_pend -> SEND; after that DONE
//               loads 8'h0A, clears lf_pend -> SEND (no FIFO read). tx_count counts both.
//   undefined : bytes passed unchanged; lf_pend logic absent.
// TESTING
//  1 reset: n_rst_out=0 with fifo non-empty -> fifo_rd_en, uart_tx_en, busy, tx_count=0.
//  2 single byte 8'h55, ready model high, drops 5 cycles after en -> one rd_en pulse,
//    en high 3 cycles after empty falls, data=8'h55 stable, tx_count=1, busy low after ready.
//  3 burst 8'h01..8'h10 (16 bytes), slow ready model (clk_out/163) -> 16 rd_en pulses,
//    bytes emitted in order, no overlap of en, tx_count=16, fifo_empty at end.
//  4 ready held high forever after en -> timeout_err=1 at TIMEOUT_CYCLES, en low, FSM
//    returns IDLE when rdy_s=1 and next byte proceeds; timeout_err stays 1.
//  5 LF_TO_CRLF_EN defined, FIFO 8'h41,8'h0A -> uart_tx sees 8'h41,8'h0D,8'h0A, tx_count=3,
//    only 2 rd_en pulses; undefined -> 8'h41,8'h0A, tx_count=2.
//  6 reset asserted while uart_tx_en=1 -> en low immediately; after release, remaining FIFO
//    bytes sent, tx_count restarted from 0.

Source files
------------

// File: rtl/fifo_uart_tx_drain.sv
// fifo_uart_tx_drain: drains sync_fifo one byte at a time into uart_tx over an en/ready handshake.
// Optional macro LF_TO_CRLF_EN expands every LF byte into the pair CR, LF.
module fifo_uart_tx_drain #(
    parameter int DATA_BITS      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int COUNT_BITS     = 16
) (
    input  logic                  dev_clk,
    input  logic                  n_rst_out,
    input  logic                  fifo_empty,
    input  logic [DATA_BITS-1:0]  fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  uart_tx_ready,
    output logic                  uart_tx_en,
    output logic [DATA_BITS-1:0]  uart_tx_data,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] tx_count,
    output logic                  timeout_err,
    output logic [2:0]            state_dbg
);
    localparam int TIMER_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);
`ifdef LF_TO_CRLF_EN
    localparam logic [DATA_BITS-1:0] CHAR_LF = DATA_BITS'(8'h0A);
    localparam logic [DATA_BITS-1:0] CHAR_CR = DATA_BITS'(8'h0D);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [DATA_BITS-1:0]    hold_q, hold_d;
    logic [TIMER_BITS-1:0]   timer_q, timer_d;
    logic [COUNT_BITS-1:0]   count_q, count_d;
    logic                    err_q, err_d;
    logic                    rdy_s;
`ifdef LF_TO_CRLF_EN
    logic                    lf_pend_q, lf_pend_d;
`endif

    assign rdy_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge dev_clk or negedge n_rst_out) begin
        if (!n_rst_out) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hold_q    <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
`ifdef LF_TO_CRLF_EN
            lf_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            err_q     <= err_d;
`ifdef LF_TO_CRLF_EN
            lf_pend_q <= lf_pend_d;
`endif
        end
    end

    // Strobes are decoded from the state register so reset removes them asynchronously.
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], uart_tx_ready};
        hold_d     = hold_q;
        timer_d    = timer_q;
        count_d    = count_q;
        err_d      = err_q;
        fifo_rd_en = 1'b0;
        uart_tx_en = 1'b0;
`ifdef LF_TO_CRLF_EN
        lf_pend_d  = lf_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && rdy_s) state_d = READ;
            end
            READ: begin
                fifo_rd_en = 1'b1;
                state_d    = LATCH;
            end
            LATCH: begin
                hold_d  = fifo_rd_data;
                timer_d = '0;
                state_d = SEND;
`ifdef LF_TO_CRLF_EN
                if (fifo_rd_data == CHAR_LF) begin
                    hold_d    = CHAR_CR;
                    lf_pend_d = 1'b1;
                end
`endif
            end
            SEND: begin
                uart_tx_en = 1'b1;
                // ready falling means uart_tx has taken the byte and started its frame
                if (!rdy_s) begin
                    count_d = count_q + COUNT_BITS'(1);
                    state_d = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + TIMER_BITS'(1);
                end
            end
            DONE: begin
                if (rdy_s) begin
                    state_d = IDLE;
`ifdef LF_TO_CRLF_EN
                    if (lf_pend_q) begin
                        hold_d    = CHAR_LF;
                        lf_pend_d = 1'b0;
                        timer_d   = '0;
                        state_d   = SEND;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign uart_tx_data = hold_q;
    assign busy         = (state_q != IDLE);
    assign tx_count     = count_q;
    assign timeout_err  = err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: FIFO and uart_tx behavioural models, byte-stream reference model.
// Build with +define+LF_TO_CRLF_EN to exercise the CR/LF expansion.
module tb_fifo_uart_tx_drain;
    localparam int DW = 8;
    localparam int CB = 5;
    localparam int TO = 4096;

    logic          dev_clk = 1'b0;
    logic          n_rst_out = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          uart_tx_ready;
    logic          uart_tx_en;
    logic [DW-1:0] uart_tx_data;
    logic          busy;
    logic [CB-1:0] tx_count;
    logic          timeout_err;
    logic [2:0]    state_dbg;

    fifo_uart_tx_drain #(
        .DATA_BITS(DW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .COUNT_BITS(CB)
    ) dut (
        .dev_clk(dev_clk), .n_rst_out(n_rst_out), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .uart_tx_ready(uart_tx_ready),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .busy(busy),
        .tx_count(tx_count), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #20 dev_clk = ~dev_clk;

    int n_checks = 0;
    int n_pass = 0;

    // reference model state: bytes uart_tx must see, bytes handed over since last reset
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_q[$];
    int total_sent = 0;

    // sync_fifo model: data appears one clock after the read strobe
    assign fifo_empty = (fifo_q.size() == 0);
    always @(posedge dev_clk)
        if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();

    // uart_tx model: takes the byte on en, drops ready after drop_dly, frame lasts frame_len
    bit stuck = 1'b0;
    bit model_busy = 1'b0;
    int drop_dly = 5;
    int frame_len = 20;
    initial begin
        uart_tx_ready = 1'b1;
        forever begin
            @(negedge dev_clk);
            if (n_rst_out && uart_tx_en === 1'b1 && !stuck) begin
                model_busy = 1'b1;
                rx_q.push_back(uart_tx_data);
                repeat (drop_dly) @(negedge dev_clk);
                uart_tx_ready = 1'b0;
                repeat (frame_len) @(negedge dev_clk);
                uart_tx_ready = 1'b1;
                model_busy = 1'b0;
            end
        end
    end

    // protocol monitor
    int rd_pulses = 0;
    int stab_err = 0;
    int proto_err = 0;
    logic prev_en = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge dev_clk) begin
        if (!n_rst_out) begin
            prev_en = 1'b0;
        end else begin
            if (fifo_rd_en === 1'b1) rd_pulses++;
            if (fifo_rd_en === 1'b1 && fifo_empty) proto_err++;
            if (uart_tx_en && prev_en && uart_tx_data !== prev_data) stab_err++;
            if (uart_tx_en && !prev_en && !uart_tx_ready) proto_err++;
            prev_en = uart_tx_en;
            prev_data = uart_tx_data;
        end
    end

    task automatic push_byte(input logic [DW-1:0] b);
        fifo_q.push_back(b);
`ifdef LF_TO_CRLF_EN
        if (b == 8'h0A) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(b);
        end
`else
        exp_q.push_back(b);
`endif
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge dev_clk);
            if (fifo_q.size() == 0 && !busy && !model_busy && uart_tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok, bad;
        n_rst_out = 1'b0;
        @(negedge dev_clk);
        push_byte(8'hA5);
        repeat (3) @(negedge dev_clk);
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
        n_checks++; if (uart_tx_en !== 1'b0) $display("FAIL reset_en: got %b want 0", uart_tx_en); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (tx_count !== '0) $display("FAIL reset_count: got %0d want 0", tx_count); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_checks++; if (uart_tx_data !== '0) $display("FAIL reset_data: got %h want 00", uart_tx_data); else n_pass++;
        drop_dly = 3; frame_len = 10;
        n_rst_out = 1'b1;
        wait_drain(2000, ok);
        n_checks++; if (!ok) $display("FAIL reset_drain: got timeout want drained"); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL reset_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_single_byte;
        bit ok, bad;
        int rd0, st0;
        drop_dly = 5; frame_len = 20;
        repeat (4) @(negedge dev_clk);
        rd0 = rd_pulses; st0 = stab_err;
        push_byte(8'h55);
        repeat (2) @(posedge dev_clk);
        @(negedge dev_clk);
        n_checks++; if (uart_tx_en !== 1'b0) $display("FAIL single_en_early: got %b want 0", uart_tx_en); else n_pass++;
        @(posedge dev_clk);
        @(negedge dev_clk);
        n_checks++; if (uart_tx_en !== 1'b1) $display("FAIL single_en_latency: got %b want 1", uart_tx_en); else n_pass++;
        n_checks++; if (uart_tx_data !== 8'h55) $display("FAIL single_data: got %h want 55", uart_tx_data); else n_pass++;
        wait_drain(500, ok);
        n_checks++; if (!ok) $display("FAIL single_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (rd_pulses - rd0 != 1) $display("FAIL single_rd_pulses: got %0d want 1", rd_pulses - rd0); else n_pass++;
        n_checks++; if (stab_err != st0) $display("FAIL single_stable: got %0d changes want 0", stab_err - st0); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL single_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
        n_checks++; if (tx_count !== CB'(total_sent)) $display("FAIL single_count: got %0d want %0d", tx_count, CB'(total_sent)); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_burst;
        bit ok, bad;
        int rd0, st0, pe0;
        drop_dly = 2; frame_len = 163;
        rd0 = rd_pulses; st0 = stab_err; pe0 = proto_err;
        for (int i = 1; i <= 16; i++) push_byte(DW'(i));
        wait_drain(16 * 200 + 500, ok);
        n_checks++; if (!ok) $display("FAIL burst_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (rd_pulses - rd0 != 16) $display("FAIL burst_rd_pulses: got %0d want 16", rd_pulses - rd0); else n_pass++;
        n_checks++; if (stab_err != st0 || proto_err != pe0) $display("FAIL burst_protocol: got %0d/%0d errors want 0", stab_err - st0, proto_err - pe0); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL burst_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
        n_checks++; if (tx_count !== CB'(total_sent)) $display("FAIL burst_count: got %0d want %0d", tx_count, CB'(total_sent)); else n_pass++;
        n_checks++; if (fifo_empty !== 1'b1) $display("FAIL burst_empty: got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_timeout;
        bit ok, bad;
        int en_cycles, w;
        stuck = 1'b1; drop_dly = 4; frame_len = 12;
        fifo_q.push_back(8'h77);
        w = 0;
        while (uart_tx_en !== 1'b1 && w < 20) begin @(negedge dev_clk); w++; end
        en_cycles = 0;
        while (uart_tx_en === 1'b1 && en_cycles < TO + 100) begin en_cycles++; @(negedge dev_clk); end
        n_checks++; if (en_cycles != TO) $display("FAIL timeout_en_cycles: got %0d want %0d", en_cycles, TO); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_flag: got %b want 1", timeout_err); else n_pass++;
        repeat (3) @(negedge dev_clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL timeout_idle: got busy %b want 0", busy); else n_pass++;
        stuck = 1'b0;
        push_byte(8'h78);
        wait_drain(500, ok);
        n_checks++; if (!ok) $display("FAIL timeout_next_drain: got timeout want drained"); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL timeout_next_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
        n_checks++; if (tx_count !== CB'(total_sent)) $display("FAIL timeout_count: got %0d want %0d", tx_count, CB'(total_sent)); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else n_pass++;
    endtask

    task automatic test_crlf;
        bit ok, bad;
        int rd0;
        drop_dly = 3; frame_len = 15;
        rd0 = rd_pulses;
        push_byte(8'h41);
        push_byte(8'h0A);
        wait_drain(1000, ok);
        n_checks++; if (!ok) $display("FAIL crlf_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (rd_pulses - rd0 != 2) $display("FAIL crlf_rd_pulses: got %0d want 2", rd_pulses - rd0); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL crlf_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
        n_checks++; if (tx_count !== CB'(total_sent)) $display("FAIL crlf_count: got %0d want %0d", tx_count, CB'(total_sent)); else n_pass++;
    endtask

    task automatic test_random;
        bit ok, bad;
        int rd0, pe0, st0;
        logic [DW-1:0] b;
        drop_dly = $urandom_range(1, 6);
        frame_len = $urandom_range(6, 40);
        rd0 = rd_pulses; pe0 = proto_err; st0 = stab_err;
        for (int i = 0; i < 24; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'h0A : DW'($urandom_range(0, 255));
            push_byte(b);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 60)) @(negedge dev_clk);
        end
        wait_drain(48 * 60 + 500, ok);
        n_checks++; if (!ok) $display("FAIL random_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (rd_pulses - rd0 != 24) $display("FAIL random_rd_pulses: got %0d want 24", rd_pulses - rd0); else n_pass++;
        n_checks++; if (stab_err != st0 || proto_err != pe0) $display("FAIL random_protocol: got %0d/%0d errors want 0", stab_err - st0, proto_err - pe0); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL random_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
        n_checks++; if (tx_count !== CB'(total_sent)) $display("FAIL random_count_wrap: got %0d want %0d", tx_count, CB'(total_sent)); else n_pass++;
    endtask

    task automatic test_reset_mid_send;
        bit ok, bad;
        int w;
        stuck = 1'b1; drop_dly = 3; frame_len = 10;
        fifo_q.push_back(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        w = 0;
        while (uart_tx_en !== 1'b1 && w < 20) begin @(negedge dev_clk); w++; end
        repeat (5) @(negedge dev_clk);
        n_checks++; if (uart_tx_en !== 1'b1) $display("FAIL midreset_en_before: got %b want 1", uart_tx_en); else n_pass++;
        n_rst_out = 1'b0;
        #1;
        n_checks++; if (uart_tx_en !== 1'b0) $display("FAIL midreset_en_async: got %b want 0", uart_tx_en); else n_pass++;
        n_checks++; if (tx_count !== '0) $display("FAIL midreset_count: got %0d want 0", tx_count); else n_pass++;
        total_sent = 0;
        @(negedge dev_clk);
        stuck = 1'b0;
        n_rst_out = 1'b1;
        wait_drain(1000, ok);
        n_checks++; if (!ok) $display("FAIL midreset_drain: got timeout want drained"); else n_pass++;
        bad = (rx_q.size() != exp_q.size());
        foreach (exp_q[i]) if (!bad && rx_q[i] !== exp_q[i]) bad = 1'b1;
        n_checks++; if (bad) $display("FAIL midreset_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        total_sent += exp_q.size(); exp_q.delete(); rx_q.delete();
        n_checks++; if (tx_count !== CB'(total_sent)) $display("FAIL midreset_count_after: got %0d want %0d", tx_count, CB'(total_sent)); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL midreset_err_cleared: got %b want 0", timeout_err); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_burst;
        test_timeout;
        test_crlf;
        test_random;
        test_reset_mid_send;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
